// File: rtl/logic_arb_pkg.sv
// Shared types and helpers for the round-robin register-slave arbiter.
// Holds the FSM state encoding, default bus widths and the index-width function.
package logic_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 32;

    // A single master still needs a one-bit index so the vectors stay legal
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/logic_slave_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
// The master served last is searched last, so it has the lowest priority.
module rr_pick
    import logic_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      grant,
    output logic               any_req
);

    // Scan offsets 1..NUM_REQ from last_grant and keep the first hit
    always_comb begin
        int          sum_v;
        logic [IW-1:0] idx_v;
        logic        found_v;
        grant   = '0;
        found_v = 1'b0;
        any_req = |req;
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum_v = int'(last_grant) + off;
            idx_v = (sum_v >= NUM_REQ) ? IW'(sum_v - NUM_REQ) : IW'(sum_v);
            if (!found_v && req[idx_v]) begin
                grant   = idx_v;
                found_v = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
    end

endmodule

// File: rtl/logic_slave_arbiter.sv
// Shares one zero-latency register slave between NUM_REQ Avalon-MM masters.
// Each access takes an IDLE (arbitrate and latch) cycle and an ISSUE cycle.
module logic_slave_arbiter
    import logic_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0] m_address,
    input  logic [NUM_REQ-1:0]        m_read,
    input  logic [NUM_REQ-1:0]        m_write,
    input  logic [NUM_REQ*DATA_W-1:0] m_writedata,
    output logic [NUM_REQ*DATA_W-1:0] m_readdata,
    output logic [NUM_REQ-1:0]        m_waitrequest,
    output logic [ADDR_W-1:0]         s_address,
    output logic                      s_read,
    output logic                      s_write,
    output logic [DATA_W-1:0]         s_writedata,
    input  logic [DATA_W-1:0]         s_readdata,
    output logic [2:0]                grant_id,
    output logic                      busy
);

    localparam int IW = idx_w(NUM_REQ);

    arb_state_e          state_r;
    arb_state_e          state_nxt_s;
    logic                load_s;
    logic [IW-1:0]       grant_r;
    logic [IW-1:0]       last_grant_r;
    logic [IW-1:0]       pick_s;
    logic                any_req_s;
    logic [NUM_REQ-1:0]  req_s;
    logic [NUM_REQ-1:0]  onehot_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                sel_wr_s;
    logic                sel_rd_s;
    logic [2:0]          grant_id_r;
    logic [ADDR_W-1:0]   s_address_r;
    logic                s_read_r;
    logic                s_write_r;
    logic [DATA_W-1:0]   s_writedata_r;
    logic [NUM_REQ-1:0]  wait_r;
    logic                busy_r;

    assign req_s = m_read | m_write;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (pick_s),
        .any_req    (any_req_s)
    );

    // Select the picked master's command; write beats read when both are set
    always_comb begin
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        onehot_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_s == IW'(i)) begin
                sel_addr_s  = m_address[i*ADDR_W +: ADDR_W];
                sel_wdata_s = m_writedata[i*DATA_W +: DATA_W];
                onehot_s[i] = 1'b1;
            end else begin
                onehot_s[i] = 1'b0;
            end
        end
        sel_wr_s = m_write[pick_s];
        sel_rd_s = m_read[pick_s] & ~m_write[pick_s];
    end

    // Next-state logic: IDLE latches a command when anyone asks, ISSUE lasts one cycle
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ISSUE;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    load_s      = 1'b0;
                end
            end
            ISSUE:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, grant bookkeeping and the registered slave command / master handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            grant_r       <= '0;
            last_grant_r  <= IW'(NUM_REQ - 1);
            grant_id_r    <= 3'd0;
            s_address_r   <= '0;
            s_read_r      <= 1'b0;
            s_write_r     <= 1'b0;
            s_writedata_r <= '0;
            wait_r        <= '1;
            busy_r        <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (load_s) begin
                grant_r       <= pick_s;
                last_grant_r  <= pick_s;
                grant_id_r    <= 3'(pick_s);
                s_address_r   <= sel_addr_s;
                s_read_r      <= sel_rd_s;
                s_write_r     <= sel_wr_s;
                s_writedata_r <= sel_wdata_s;
                wait_r        <= ~onehot_s;
                busy_r        <= 1'b1;
            end else begin
                s_read_r  <= 1'b0;
                s_write_r <= 1'b0;
                wait_r    <= '1;
                busy_r    <= 1'b0;
            end
        end
    end

    // Zero-latency slave data is steered only to the master being served
    always_comb begin
        m_readdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_r == ISSUE) && s_read_r && (grant_r == IW'(i))) begin
                m_readdata[i*DATA_W +: DATA_W] = s_readdata;
            end else begin
                m_readdata[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

    assign m_waitrequest = wait_r;
    assign s_address     = s_address_r;
    assign s_read        = s_read_r;
    assign s_write       = s_write_r;
    assign s_writedata   = s_writedata_r;
    assign grant_id      = grant_id_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_logic_slave_arbiter.sv
// Directed bench for logic_slave_arbiter: a 2-master instance with a register
// slave model and a 4-master instance for the full-rotation fairness case.
module tb_logic_slave_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          checks = 0;
    int          failures = 0;

    logic [3:0]  m_address2;
    logic [1:0]  m_read2, m_write2, m_wait2;
    logic [63:0] m_writedata2, m_readdata2;
    logic [1:0]  s_address2;
    logic        s_read2, s_write2, busy2;
    logic [31:0] s_writedata2, s_readdata2;
    logic [2:0]  grant_id2;
    logic [31:0] slave_reg = 32'd0;

    logic [7:0]   m_address4;
    logic [3:0]   m_read4, m_write4, m_wait4;
    logic [127:0] m_writedata4, m_readdata4;
    logic [1:0]   s_address4;
    logic         s_read4, s_write4, busy4;
    logic [31:0]  s_writedata4;
    logic [31:0]  s_readdata4 = 32'd0;
    logic [2:0]   grant_id4;

    always #5 clk = ~clk;

    logic_slave_arbiter #(.NUM_REQ(2), .ADDR_W(2), .DATA_W(32)) dut2 (
        .clk(clk), .reset_n(reset_n), .m_address(m_address2), .m_read(m_read2),
        .m_write(m_write2), .m_writedata(m_writedata2), .m_readdata(m_readdata2),
        .m_waitrequest(m_wait2), .s_address(s_address2), .s_read(s_read2),
        .s_write(s_write2), .s_writedata(s_writedata2), .s_readdata(s_readdata2),
        .grant_id(grant_id2), .busy(busy2)
    );

    logic_slave_arbiter #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(32)) dut4 (
        .clk(clk), .reset_n(reset_n), .m_address(m_address4), .m_read(m_read4),
        .m_write(m_write4), .m_writedata(m_writedata4), .m_readdata(m_readdata4),
        .m_waitrequest(m_wait4), .s_address(s_address4), .s_read(s_read4),
        .s_write(s_write4), .s_writedata(s_writedata4), .s_readdata(s_readdata4),
        .grant_id(grant_id4), .busy(busy4)
    );

    // Storage register at address 0, zero-latency read
    always @(posedge clk) begin
        if (s_write2 && s_address2 == 2'd0) slave_reg <= s_writedata2;
    end
    assign s_readdata2 = (s_address2 == 2'd0) ? slave_reg : 32'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        m_address2 = '0; m_read2 = '0; m_write2 = '0; m_writedata2 = '0;
        m_address4 = '0; m_read4 = '0; m_write4 = '0; m_writedata4 = '0;
        reset_n = 1'b0;
        tick(); tick();
        checks++; if (m_wait2 !== 2'b11) begin failures++; $display("FAIL reset_wait2 got=%b exp=11", m_wait2); end
        checks++; if ({s_read2, s_write2, busy2} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {s_read2, s_write2, busy2}); end
        checks++; if (s_address2 !== 2'd0 || s_writedata2 !== 32'd0) begin failures++; $display("FAIL reset_cmd got=%h/%h exp=0/0", s_address2, s_writedata2); end
        checks++; if (grant_id2 !== 3'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id2); end
        checks++; if (m_readdata2 !== 64'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", m_readdata2); end
        checks++; if (m_wait4 !== 4'hf || busy4 !== 1'b0) begin failures++; $display("FAIL reset_dut4 got=%b/%b exp=1111/0", m_wait4, busy4); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        m_write2 = 2'b01; m_address2 = 4'h0; m_writedata2 = {32'd0, 32'h0000_00A5};
        checks++; if (m_wait2 !== 2'b11 || s_write2 !== 1'b0) begin failures++; $display("FAIL wr_cycle1 got=%b/%b exp=11/0", m_wait2, s_write2); end
        tick();
        checks++; if (s_write2 !== 1'b1 || s_writedata2 !== 32'h0000_00A5) begin failures++; $display("FAIL wr_issue got=%b/%h exp=1/a5", s_write2, s_writedata2); end
        checks++; if (m_wait2 !== 2'b10) begin failures++; $display("FAIL wr_wait got=%b exp=10", m_wait2); end
        checks++; if (grant_id2 !== 3'd0 || busy2 !== 1'b1) begin failures++; $display("FAIL wr_grant got=%0d/%b exp=0/1", grant_id2, busy2); end
        m_write2 = 2'b00;
        tick();
        checks++; if (s_write2 !== 1'b0 || m_wait2 !== 2'b11 || busy2 !== 1'b0) begin failures++; $display("FAIL wr_done got=%b/%b/%b exp=0/11/0", s_write2, m_wait2, busy2); end
    endtask

    task automatic test_single_read();
        m_read2 = 2'b10; m_address2 = 4'h0;
        checks++; if (m_wait2 !== 2'b11) begin failures++; $display("FAIL rd_cycle1 got=%b exp=11", m_wait2); end
        tick();
        checks++; if (m_wait2 !== 2'b01 || s_read2 !== 1'b1 || grant_id2 !== 3'd1) begin failures++; $display("FAIL rd_issue got=%b/%b/%0d exp=01/1/1", m_wait2, s_read2, grant_id2); end
        checks++; if (m_readdata2[63:32] !== 32'h0000_00A5) begin failures++; $display("FAIL rd_data1 got=%h exp=a5", m_readdata2[63:32]); end
        checks++; if (m_readdata2[31:0] !== 32'd0) begin failures++; $display("FAIL rd_data0 got=%h exp=0", m_readdata2[31:0]); end
        m_read2 = 2'b00;
        tick();
        checks++; if (s_read2 !== 1'b0 || m_readdata2 !== 64'd0) begin failures++; $display("FAIL rd_done got=%b/%h exp=0/0", s_read2, m_readdata2); end
    endtask

    task automatic test_contention();
        int g;
        do_reset();
        m_write2 = 2'b11; m_writedata2 = {32'h0000_0022, 32'h0000_0011};
        for (int c = 1; c <= 8; c++) begin
            if (c % 2 == 0) begin
                g = (c / 2 - 1) % 2;
                checks++; if (grant_id2 !== 3'(g) || m_wait2 !== ((g == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_grant c=%0d got=%0d/%b exp=%0d", c, grant_id2, m_wait2, g); end
                checks++; if (s_write2 !== 1'b1 || s_writedata2 !== ((g == 0) ? 32'h11 : 32'h22)) begin failures++; $display("FAIL rr_data c=%0d got=%b/%h", c, s_write2, s_writedata2); end
            end else begin
                checks++; if (m_wait2 !== 2'b11 || s_write2 !== 1'b0) begin failures++; $display("FAIL rr_idle c=%0d got=%b/%b exp=11/0", c, m_wait2, s_write2); end
            end
            tick();
        end
        m_write2 = 2'b00;
        tick();
    endtask

    task automatic test_read_write();
        m_read2 = 2'b01; m_write2 = 2'b01; m_writedata2 = {32'd0, 32'h0000_0033};
        tick();
        checks++; if (s_write2 !== 1'b1 || s_read2 !== 1'b0) begin failures++; $display("FAIL rw_strobes got=w%b r%b exp=w1 r0", s_write2, s_read2); end
        checks++; if (s_writedata2 !== 32'h33 || m_readdata2 !== 64'd0) begin failures++; $display("FAIL rw_data got=%h/%h exp=33/0", s_writedata2, m_readdata2); end
        m_read2 = 2'b00; m_write2 = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_issue();
        m_write2 = 2'b10; m_writedata2 = {32'h0000_0044, 32'h0000_0055};
        tick();
        checks++; if (s_write2 !== 1'b1 || grant_id2 !== 3'd1) begin failures++; $display("FAIL rst_pre got=%b/%0d exp=1/1", s_write2, grant_id2); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (s_write2 !== 1'b0 || m_wait2 !== 2'b11 || busy2 !== 1'b0) begin failures++; $display("FAIL rst_abort got=%b/%b/%b exp=0/11/0", s_write2, m_wait2, busy2); end
        tick();
        reset_n = 1'b1; m_write2 = 2'b11;
        tick();
        checks++; if (grant_id2 !== 3'd0 || m_wait2 !== 2'b10 || s_writedata2 !== 32'h55) begin failures++; $display("FAIL rst_next got=%0d/%b/%h exp=0/10/55", grant_id2, m_wait2, s_writedata2); end
        m_write2 = 2'b00;
        tick();
    endtask

    task automatic test_four();
        int g;
        int done [4];
        logic [3:0] exp_w;
        for (int i = 0; i < 4; i++) done[i] = 0;
        do_reset();
        m_write4 = 4'hf;
        m_address4 = {2'd3, 2'd2, 2'd1, 2'd0};
        m_writedata4 = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int c = 1; c <= 16; c++) begin
            for (int i = 0; i < 4; i++) if (!m_wait4[i]) done[i]++;
            if (c % 2 == 0) begin
                g = (c / 2 - 1) % 4;
                exp_w = ~(4'b0001 << g);
                checks++; if (grant_id4 !== 3'(g) || m_wait4 !== exp_w) begin failures++; $display("FAIL rr4_grant c=%0d got=%0d/%b exp=%0d/%b", c, grant_id4, m_wait4, g, exp_w); end
                checks++; if (s_writedata4 !== 32'(g + 1) || s_address4 !== 2'(g)) begin failures++; $display("FAIL rr4_cmd c=%0d got=%h/%0d exp=%0d/%0d", c, s_writedata4, s_address4, g + 1, g); end
            end else begin
                checks++; if (m_wait4 !== 4'hf) begin failures++; $display("FAIL rr4_idle c=%0d got=%b exp=1111", c, m_wait4); end
            end
            tick();
        end
        m_write4 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (done[i] !== 2) begin failures++; $display("FAIL rr4_count m=%0d got=%0d exp=2", i, done[i]); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_read_write();
        test_reset_mid_issue();
        test_four();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
